// File: rtl/bit_serializer_if.sv
// Load/stream bundle for bit_serializer.
//   load_data/load_len/load_valid/abort : requester -> serializer
//   load_ready                          : serializer accepts a word while high
//   x/x_valid                           : serial stream, MSB of the word first
//   busy/done                           : transfer in progress / one-cycle completion pulse
interface bit_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] load_data;
  logic [4:0]       load_len;
  logic             load_valid;
  logic             load_ready;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_data, load_len, load_valid, abort,
    input  load_ready, x, x_valid, busy, done
  );

  modport slave (
    input  load_data, load_len, load_valid, abort,
    output load_ready, x, x_valid, busy, done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding a downstream sequence detector.
// A word accepted in IDLE is sent MSB first, one bit per cycle, for the
// effective length N (0 or >WIDTH means WIDTH). The last bit is followed by a single
// DONE cycle. An abort in SHIFT drops the rest of the word without a done pulse.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : bit_serializer_if.slave (load request in, serial stream/status out)
// Every output is a flop; next values are computed from state and inputs
// and captured on the edge, so no input reaches an output combinationally.
module bit_serializer #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  bit_serializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] WL = 5'(WIDTH);

  state_t           state, state_d;
  logic [WIDTH-1:0] sr, sr_d;
  // Bits still to send after the one currently on x.
  logic [4:0]       cnt, cnt_d;
  logic             x_d, xv_d, busy_d, done_d, rdy_d;
  logic [4:0]       len_eff;

  assign len_eff = (bus.load_len == 5'd0 || bus.load_len > WL) ? WL : bus.load_len;

  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rdy_d   = 1'b0;
    case (state)
      IDLE: begin
        rdy_d = 1'b1;
        // abort is meaningless here, so a simultaneous load still goes through.
        if (bus.load_valid) begin
          state_d = SHIFT;
          x_d     = bus.load_data[WIDTH-1];
          xv_d    = 1'b1;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
          sr_d    = bus.load_data << 1;
          cnt_d   = len_eff - 5'd1;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
        end else if (cnt == 5'd0) begin
          // Stops on the count, so bits below N never reach x.
          state_d = DONE;
          sr_d    = '0;
          done_d  = 1'b1;
        end else begin
          x_d   = sr[WIDTH-1];
          xv_d  = 1'b1;
          sr_d  = sr << 1;
          cnt_d = cnt - 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      sr             <= '0;
      cnt            <= '0;
      bus.x          <= 1'b0;
      bus.x_valid    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.load_ready <= 1'b1;
    end else begin
      state          <= state_d;
      sr             <= sr_d;
      cnt            <= cnt_d;
      bus.x          <= x_d;
      bus.x_valid    <= xv_d;
      bus.busy       <= busy_d;
      bus.done       <= done_d;
      bus.load_ready <= rdy_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  bit_serializer_if #(.WIDTH(W)) bus ();

  bit_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   n_chk   = 0;
  int   n_fail  = 0;
  int   done_exp = 0;
  logic exp_q[$];
  bit   mon_on  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every valid bit must match the next queued bit,
  // x must idle at 0, and each done pulse must have been expected.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.x_valid) begin
        chk("bit_queue_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("serial_bit", bus.x, exp_q.pop_front());
      end else begin
        chk("x_idle_zero", bus.x, 0);
      end
      if (bus.done) begin
        chk("done_expected", 32'(done_exp > 0), 1);
        if (done_exp > 0) done_exp--;
      end
    end
  end

  // Drive one load at a negedge (accepted on the next posedge) and queue the
  // first n expected bits; leaves us at the negedge where bit 0 is on x.
  task automatic start(input logic [W-1:0] d, input logic [4:0] len, input int n,
                       input logic ab, input bit exp_done);
    int cyc = 0;
    while (!bus.load_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ready_before_load", bus.load_ready, 1);
    bus.load_data  = d;
    bus.load_len   = len;
    bus.load_valid = 1'b1;
    bus.abort      = ab;
    for (int i = 0; i < n; i++) exp_q.push_back(d[W-1-i]);
    if (exp_done) done_exp++;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.abort      = 1'b0;
  endtask

  // From bit-0 cycle, wait for done: it must come in cycle n+1, and
  // load_ready must be back one cycle later (accept spacing n+2).
  task automatic finish_xfer(input string tag, input int n);
    int cyc = 1;
    while (!bus.done && cyc < 60) begin @(negedge clk); cyc++; end
    chk({tag, "_done_cycle"}, cyc, n + 1);
    chk({tag, "_done_busy"}, bus.busy, 1);
    chk({tag, "_done_ready"}, bus.load_ready, 0);
    @(negedge clk);
    chk({tag, "_ready_after"}, bus.load_ready, 1);
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_done_once"}, bus.done, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, bus.load_ready, 1);
    chk({tag, "_x"}, bus.x, 0);
    chk({tag, "_xv"}, bus.x_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.load_data  = '0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.abort      = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    check_idle("reset");
    mon_on = 1'b1;

    // Full-width word.
    start(16'b0101001101101011, 5'd16, 16, 1'b0, 1'b1);
    chk("bit0_latency_xv", bus.x_valid, 1);
    chk("bit0_busy", bus.busy, 1);
    finish_xfer("full16", 16);

    // Short length: only the top 4 bits.
    start(16'hA000, 5'd4, 4, 1'b0, 1'b1);
    finish_xfer("len4", 4);

    // Length 0 means full width.
    start(16'hA000, 5'd0, 16, 1'b0, 1'b1);
    finish_xfer("len0", 16);

    // Length above WIDTH is clamped.
    start(16'hC3A5, 5'd20, 16, 1'b0, 1'b1);
    finish_xfer("len20", 16);

    // Single bit, with abort high in IDLE (must not block the load).
    start(16'h8001, 5'd1, 1, 1'b1, 1'b1);
    finish_xfer("len1_abort_idle", 1);

    // Abort while bit 5 is on x: bits 0..5 sent, then idle, no done.
    start(16'hFFFF, 5'd16, 6, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("abort_bit5_xv", bus.x_valid, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("after_abort");
    repeat (3) @(negedge clk);
    chk("abort_no_done_pending", done_exp, 0);

    // Reset while bit 8 is on x.
    start(16'h5AA5, 5'd16, 9, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("after_mid_reset");
    repeat (3) @(negedge clk);
    check_idle("reset_settled");

    // New load during SHIFT must be ignored.
    start(16'h1234, 5'd16, 16, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    bus.load_data  = 16'hFFFF;
    bus.load_len   = 5'd3;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ignored_load_ready_low", bus.load_ready, 0);
    end
    bus.load_valid = 1'b0;
    begin
      int cyc = 8;
      while (!bus.done && cyc < 60) begin @(negedge clk); cyc++; end
      chk("ignored_done_cycle", cyc, 17);
    end
    @(negedge clk);
    chk("ignored_ready_after", bus.load_ready, 1);

    // Back-to-back short transfers at minimum spacing.
    start(16'h4000, 5'd2, 2, 1'b0, 1'b1);
    finish_xfer("b2b_a", 2);
    start(16'hC000, 5'd3, 3, 1'b0, 1'b1);
    finish_xfer("b2b_b", 3);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("done_count", done_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001: Parameter WIDTH, default 16, shift-register width in bits; legal range 2..31.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-low.
REQ-004: load_data  input  WIDTH  parallel word; bit WIDTH-1 is transmitted first.
REQ-005: load_len  input  5  number of bits to transmit; 0 means WIDTH; values > WIDTH are clamped to WIDTH.
REQ-006: load_valid  input  1  load request; qualifies load_data and load_len.
REQ-007: load_ready  output  1  high only in IDLE; load accepted on an edge where load_valid && load_ready.
REQ-008: abort  input  1  synchronous cancel of an in-progress transfer.
REQ-009: x  output  1  serial bit stream to the downstream sequence detector.
REQ-010: x_valid  output  1  high while x carries a transmitted bit.
REQ-011: busy  output  1  high in SHIFT and DONE.
REQ-012: done  output  1  one-cycle pulse after the last bit of a completed transfer.

Function
REQ-013: FSM states IDLE, SHIFT and DONE; all outputs SHALL be registered, with no combinational input-to-output path.
REQ-014: IDLE: load_ready=1; x=0, x_valid=0, busy=0, done=0.
REQ-015: IDLE -> SHIFT on accept edge E0; the block captures load_data into the shift register and the effective length N into a down-counter.
REQ-016: SHIFT: bit i (i=0..N-1) = load_data[WIDTH-1-i]; it SHALL be on x with x_valid=1 in the cycle following edge E0+i.
REQ-017: Each SHIFT cycle: shift register moves left by one; counter decrements by 1; x is held stable for the full cycle.
REQ-018: SHIFT -> DONE on the edge where the counter reaches 0 (edge E0+N); the DONE cycle has done=1, x=0, x_valid=0, load_ready=0.
REQ-019: DONE -> IDLE unconditionally on the next edge (E0+N+1); the minimum spacing between accepts SHALL be N+2 cycles.
REQ-020: load_valid SHALL be ignored in SHIFT and DONE; no capture and no state change.
REQ-021: abort=1 in SHIFT -> IDLE on that edge; no done pulse; the remaining bits are discarded; x=0 and x_valid=0 from the next cycle.
REQ-022: abort in IDLE or DONE SHALL have no effect; abort and load_valid both high in IDLE -> the load is accepted.
REQ-023: N=1 SHALL produce exactly one x_valid cycle followed by DONE.
REQ-024: Unused low bits of the shift register (bits beyond N) SHALL never appear on x.

Reset
REQ-025: rst=0 at any edge -> next cycle: state IDLE; x=0, x_valid=0, busy=0, done=0, load_ready=1; shift register and counter cleared.
REQ-026: Reset SHALL override abort and load_valid; reset during SHIFT discards the transfer without a done pulse.

Verification
REQ-027: Reset: rst=0 for 2 cycles, then 1 -> load_ready=1, x=0, x_valid=0, busy=0, done=0.
REQ-028: load_data=16'b0101001101101011, load_len=16 -> x=0,1,0,1,0,0,1,1,0,1,1,0,1,0,1,1 over 16 x_valid cycles, then done=1 for one cycle, then load_ready=1.
REQ-029: load_data=16'hA000, load_len=4 -> x=1,0,1,0, then done; load_len=0 with the same data -> 16 bits sent.
REQ-030: Abort: abort=1 during bit 5 of a 16-bit transfer -> x_valid=0 next cycle, done stays 0, load_ready=1.
REQ-031: Reset mid-transfer: rst=0 during bit 8 -> all outputs return to reset values; no done pulse.
REQ-032: Ignored load: load_valid=1 with new data during SHIFT -> the current stream is unaffected and the new data is not captured.
